// File: rtl/deserializator.sv
// Rebuilds MSB-first serial bit streams into left-aligned parallel words with a
// valid-bit count; a partial word is closed after GAP_CYCLES idle cycles.
module deserializator #(
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 1,
  localparam int MOD_W     = $clog2(DATA_W),
  localparam int CNT_W     = $clog2(DATA_W + 1),
  localparam int GAP_W     = $clog2(GAP_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              short_frame_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, GAP} state_t;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] acc_sampled;
  logic [MOD_W-1:0]  bit_idx;
  logic              full_done;
  logic              gap_done;
  state_t            state;

  logic [DATA_W-1:0] data_reg, data_next;
  logic [MOD_W-1:0]  mod_reg, mod_next;
  logic              val_reg, val_next;
  logic              short_reg, short_next;

  // The state is fully implied by the counters; decoded here for readability.
  always_comb begin
    if (cnt_reg == '0)
      state = IDLE;
    else if (gap_reg == '0)
      state = COLLECT;
    else
      state = GAP;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_reg   <= '0;
      gap_reg   <= '0;
      acc_reg   <= '0;
      data_reg  <= '0;
      mod_reg   <= '0;
      val_reg   <= 1'b0;
      short_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      acc_reg   <= acc_next;
      data_reg  <= data_next;
      mod_reg   <= mod_next;
      val_reg   <= val_next;
      short_reg <= short_next;
    end
  end

  // Next-state logic
  always_comb begin
    bit_idx              = MOD_W'(DATA_W - 1) - cnt_reg[MOD_W-1:0];
    acc_sampled          = acc_reg;
    acc_sampled[bit_idx] = ser_data_i;

    full_done = ser_data_val_i && (cnt_reg == CNT_W'(DATA_W - 1));
    gap_done  = !ser_data_val_i && (state != IDLE) &&
                (gap_reg == GAP_W'(GAP_CYCLES - 1));

    cnt_next = cnt_reg;
    gap_next = gap_reg;
    acc_next = acc_reg;

    if (ser_data_val_i) begin
      gap_next = '0;
      if (full_done) begin
        // A fresh word starts on the very next edge, so no bubble is needed.
        cnt_next = '0;
        acc_next = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
        acc_next = acc_sampled;
      end
    end else if (state != IDLE) begin
      if (gap_done) begin
        cnt_next = '0;
        gap_next = '0;
        acc_next = '0;
      end else begin
        gap_next = gap_reg + GAP_W'(1);
      end
    end
  end

  // Output logic: data/mod hold between pulses, val/short are single-cycle.
  always_comb begin
    data_next  = data_reg;
    mod_next   = mod_reg;
    val_next   = full_done || gap_done;
    short_next = gap_done && ((cnt_reg == CNT_W'(1)) || (cnt_reg == CNT_W'(2)));
    if (full_done) begin
      data_next = acc_sampled;
      mod_next  = '0;
    end else if (gap_done) begin
      data_next = acc_reg;
      mod_next  = cnt_reg[MOD_W-1:0];
    end
  end

  assign deser_data_o     = data_reg;
  assign deser_data_mod_o = mod_reg;
  assign deser_data_val_o = val_reg;
  assign short_frame_o    = short_reg;

endmodule

// File: tb/tb_deserializator.sv
// Directed bench for deserializator: one instance with GAP_CYCLES=1, one with 3.
module tb_deserializator;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        sdata = 1'b0, sval = 1'b0;
  logic        sdata3 = 1'b0, sval3 = 1'b0;
  logic [15:0] d1_data, d3_data;
  logic [3:0]  d1_mod, d3_mod;
  logic        d1_val, d3_val, d1_short, d3_short;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stray_short = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    logic        shrt;
    int          cyc;
  } pulse_t;

  pulse_t q1[$];
  pulse_t q3[$];

  always #5 clk = ~clk;

  deserializator #(.DATA_W(16), .GAP_CYCLES(1)) dut1 (
    .clk_i(clk), .srst_i(srst), .ser_data_i(sdata), .ser_data_val_i(sval),
    .deser_data_o(d1_data), .deser_data_mod_o(d1_mod),
    .deser_data_val_o(d1_val), .short_frame_o(d1_short)
  );

  deserializator #(.DATA_W(16), .GAP_CYCLES(3)) dut3 (
    .clk_i(clk), .srst_i(srst), .ser_data_i(sdata3), .ser_data_val_i(sval3),
    .deser_data_o(d3_data), .deser_data_mod_o(d3_mod),
    .deser_data_val_o(d3_val), .short_frame_o(d3_short)
  );

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (d1_val === 1'b1) q1.push_back('{d1_data, d1_mod, d1_short, cyc});
    if (d3_val === 1'b1) q3.push_back('{d3_data, d3_mod, d3_short, cyc});
    if ((d1_short === 1'b1 && d1_val !== 1'b1) || (d3_short === 1'b1 && d3_val !== 1'b1))
      stray_short = stray_short + 1;
  end

  task automatic send(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sdata = w[15-i];
      sval  = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sdata = 1'b0;
      sval  = 1'b0;
    end
  endtask

  task automatic send3(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sdata3 = w[15-i];
      sval3  = 1'b1;
    end
  endtask

  task automatic idle3(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sdata3 = 1'b0;
      sval3  = 1'b0;
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    idle(3);
    n_checks++; if (d1_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", d1_data); end
    n_checks++; if (d1_mod !== 4'h0) begin n_fail++; $display("FAIL reset_mod got %h exp 0", d1_mod); end
    n_checks++; if (d1_val !== 1'b0) begin n_fail++; $display("FAIL reset_val got %b exp 0", d1_val); end
    n_checks++; if (d1_short !== 1'b0) begin n_fail++; $display("FAIL reset_short got %b exp 0", d1_short); end
    srst = 1'b0;
    idle(6);
    n_checks++; if (q1.size() != 0) begin n_fail++; $display("FAIL idle_no_pulse got %0d pulses exp 0", q1.size()); end
    $display("test_reset: done");
  endtask

  task automatic test_full_word();
    int t_last;
    q1.delete();
    send(16'hB005, 16);
    t_last = cyc;
    n_checks++; if (q1.size() != 0) begin n_fail++; $display("FAIL full_no_early_pulse got %0d exp 0", q1.size()); end
    idle(3);
    n_checks++; if (q1.size() != 1) begin n_fail++; $display("FAIL full_count got %0d exp 1", q1.size()); end
    if (q1.size() >= 1) begin
      n_checks++; if (q1[0].data !== 16'hB005) begin n_fail++; $display("FAIL full_data got %h exp b005", q1[0].data); end
      n_checks++; if (q1[0].mod !== 4'd0) begin n_fail++; $display("FAIL full_mod got %0d exp 0", q1[0].mod); end
      n_checks++; if (q1[0].shrt !== 1'b0) begin n_fail++; $display("FAIL full_short got %b exp 0", q1[0].shrt); end
      n_checks++; if (q1[0].cyc != t_last + 1) begin n_fail++; $display("FAIL full_latency got %0d exp %0d", q1[0].cyc - t_last, 1); end
    end
    $display("test_full_word: %0d pulse(s)", q1.size());
  endtask

  task automatic test_partial();
    int t_last;
    q1.delete();
    send(16'hB000, 6);
    t_last = cyc;
    idle(4);
    n_checks++; if (q1.size() != 1) begin n_fail++; $display("FAIL partial_count got %0d exp 1", q1.size()); end
    if (q1.size() >= 1) begin
      n_checks++; if (q1[0].data !== 16'hB000) begin n_fail++; $display("FAIL partial_data got %h exp b000", q1[0].data); end
      n_checks++; if (q1[0].mod !== 4'd6) begin n_fail++; $display("FAIL partial_mod got %0d exp 6", q1[0].mod); end
      n_checks++; if (q1[0].shrt !== 1'b0) begin n_fail++; $display("FAIL partial_short got %b exp 0", q1[0].shrt); end
      n_checks++; if (q1[0].cyc != t_last + 2) begin n_fail++; $display("FAIL partial_latency got %0d exp 2", q1[0].cyc - t_last); end
    end
    n_checks++; if (d1_data !== 16'hB000) begin n_fail++; $display("FAIL partial_hold got %h exp b000", d1_data); end
    $display("test_partial: %0d pulse(s)", q1.size());
  endtask

  task automatic test_back_to_back();
    q1.delete();
    send(16'hB005, 16);
    send(16'h1234, 16);
    idle(4);
    n_checks++; if (q1.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", q1.size()); end
    if (q1.size() >= 2) begin
      n_checks++; if (q1[0].data !== 16'hB005) begin n_fail++; $display("FAIL b2b_data0 got %h exp b005", q1[0].data); end
      n_checks++; if (q1[1].data !== 16'h1234) begin n_fail++; $display("FAIL b2b_data1 got %h exp 1234", q1[1].data); end
      n_checks++; if (q1[0].mod !== 4'd0 || q1[1].mod !== 4'd0) begin n_fail++; $display("FAIL b2b_mod got %0d/%0d exp 0/0", q1[0].mod, q1[1].mod); end
      n_checks++; if (q1[1].cyc - q1[0].cyc != 16) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 16", q1[1].cyc - q1[0].cyc); end
    end
    $display("test_back_to_back: %0d pulse(s)", q1.size());
  endtask

  task automatic test_gap3();
    q3.delete();
    send3(16'hD000, 4);
    idle3(2);
    send3(16'h3000, 4);
    n_checks++; if (q3.size() != 0) begin n_fail++; $display("FAIL gap3_early got %0d pulses exp 0", q3.size()); end
    idle3(6);
    n_checks++; if (q3.size() != 1) begin n_fail++; $display("FAIL gap3_count got %0d exp 1", q3.size()); end
    if (q3.size() >= 1) begin
      n_checks++; if (q3[0].data !== 16'hD300) begin n_fail++; $display("FAIL gap3_data got %h exp d300", q3[0].data); end
      n_checks++; if (q3[0].mod !== 4'd8) begin n_fail++; $display("FAIL gap3_mod got %0d exp 8", q3[0].mod); end
    end
    $display("test_gap3: %0d pulse(s)", q3.size());
  endtask

  task automatic test_short();
    logic [15:0] w_tab [3] = '{16'h8000, 16'h8000, 16'hE000};
    int          n_tab [3] = '{2, 1, 3};
    logic        s_tab [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      q1.delete();
      send(w_tab[k], n_tab[k]);
      idle(4);
      n_checks++; if (q1.size() != 1) begin n_fail++; $display("FAIL short%0d_count got %0d exp 1", k, q1.size()); end
      if (q1.size() >= 1) begin
        n_checks++; if (q1[0].data !== w_tab[k]) begin n_fail++; $display("FAIL short%0d_data got %h exp %h", k, q1[0].data, w_tab[k]); end
        n_checks++; if (q1[0].mod !== 4'(n_tab[k])) begin n_fail++; $display("FAIL short%0d_mod got %0d exp %0d", k, q1[0].mod, n_tab[k]); end
        n_checks++; if (q1[0].shrt !== s_tab[k]) begin n_fail++; $display("FAIL short%0d_flag got %b exp %b", k, q1[0].shrt, s_tab[k]); end
      end
      $display("test_short: len %0d -> %0d pulse(s)", n_tab[k], q1.size());
    end
  endtask

  task automatic test_reset_midframe();
    q1.delete();
    send(16'h5A5A, 9);
    @(negedge clk);
    sval = 1'b0;
    srst = 1'b1;
    idle(2);
    n_checks++; if (d1_data !== 16'h0 || d1_mod !== 4'h0 || d1_val !== 1'b0 || d1_short !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got %h/%0d/%b/%b exp 0000/0/0/0", d1_data, d1_mod, d1_val, d1_short);
    end
    srst = 1'b0;
    idle(2);
    send(16'hFFFF, 16);
    idle(4);
    n_checks++; if (q1.size() != 1) begin n_fail++; $display("FAIL midrst_count got %0d exp 1", q1.size()); end
    if (q1.size() >= 1) begin
      n_checks++; if (q1[0].data !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_data got %h exp ffff", q1[0].data); end
      n_checks++; if (q1[0].mod !== 4'd0) begin n_fail++; $display("FAIL midrst_mod got %0d exp 0", q1[0].mod); end
    end
    $display("test_reset_midframe: %0d pulse(s)", q1.size());
  endtask

  task automatic test_loopback();
    logic [15:0] w_tab [3] = '{16'hB000, 16'hB005, 16'h4000};
    logic [3:0]  m_tab [3] = '{4'd6, 4'd0, 4'd2};
    q1.delete();
    for (int k = 0; k < 3; k++) begin
      send(w_tab[k], (m_tab[k] == 4'd0) ? 16 : int'(m_tab[k]));
      if (m_tab[k] != 4'd0) idle(1);
    end
    idle(4);
    n_checks++; if (q1.size() != 3) begin n_fail++; $display("FAIL loop_count got %0d exp 3", q1.size()); end
    for (int k = 0; k < 3; k++) begin
      if (q1.size() > k) begin
        n_checks++;
        if (q1[k].data !== w_tab[k] || q1[k].mod !== m_tab[k]) begin
          n_fail++; $display("FAIL loop%0d got %h/%0d exp %h/%0d", k, q1[k].data, q1[k].mod, w_tab[k], m_tab[k]);
        end
        $display("test_loopback: word %0d -> %h mod %0d", k, q1[k].data, q1[k].mod);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_gap3();
    test_short();
    test_reset_midframe();
    test_loopback();
    n_checks++; if (stray_short != 0) begin n_fail++; $display("FAIL stray_short got %0d exp 0", stray_short); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializator.md
Name: deserializator

Overview:
- Downstream companion of the 16-bit serializer.
- Consumes the MSB-first bit stream (ser_data + ser_data_val) and rebuilds parallel words together with their valid-bit count (mod, where 0 means 16).
- Output format matches the serializer's input format (data + mod + val), so a serializer→deserializer loopback returns the original word.
- Closes a partial word after a configurable gap of invalid cycles.

Parameters:
- DATA_W, 16, parallel word width; the mod field is $clog2(DATA_W) bits wide and 0 encodes a full word.
- GAP_CYCLES, 1, number of consecutive cycles with ser_data_val_i=0 that close a partial word; legal range is 1 or more.

Ports:
- clk_i  input  1  clock.
- srst_i  input  1  synchronous reset, active-high.
- ser_data_i  input  1  serial data bit, MSB of word first.
- ser_data_val_i  input  1  ser_data_i valid this cycle.
- deser_data_o  output  DATA_W  reassembled word, left-aligned; unreceived LSBs are 0.
- deser_data_mod_o  output  4  number of valid bits; 0 means 16.
- deser_data_val_o  output  1  one-cycle pulse, deser_data_o/mod valid.
- short_frame_o  output  1  pulse coincident with deser_data_val_o when mod is 1 or 2 (lengths the serializer never emits).

Behaviour:
Reset:
- All outputs are 0 on the cycle after srst_i is sampled high.
- Bit counter, gap counter and accumulator are cleared.
- srst_i has priority over every other event.
- Reset mid-frame discards the partial word; no val pulse is produced for it.

State (implicit FSM):
- IDLE: cnt=0.
- COLLECT: 0<cnt<16, gap=0.
- GAP: 0<cnt<16, gap>0.

Sampling:
- On each posedge with ser_data_val_i=1, ser_data_i is written to acc[15-cnt], cnt increments, and gap clears.

Full word:
- When the sampled bit is the 16th (cnt was 15), the next cycle drives deser_data_o=acc including that bit, mod=0 and val=1 for exactly 1 cycle.
- cnt returns to 0 and acc clears in the same edge.
- Latency: val rises 1 cycle after the edge sampling the last bit.

Back-to-back streams:
- If ser_data_val_i stays high, the 17th bit is sampled as bit 15 of the next word in the same edge that registers the completed word.
- No bubble is allowed; consecutive words may produce val pulses exactly 16 cycles apart.

Partial word:
- In COLLECT/GAP, each cycle with ser_data_val_i=0 increments gap.
- On the edge where gap reaches GAP_CYCLES, the block outputs acc (bits below 16-cnt are 0), mod=cnt and val=1, then returns to IDLE.
- If val returns before gap reaches GAP_CYCLES, the gap clears and collection continues into the same word.

IDLE with ser_data_val_i=0:
- Nothing happens; gap does not count.

Output holding:
- Outside val pulses, deser_data_o and deser_data_mod_o hold their last value.
- short_frame_o is 0 outside val pulses.

Arithmetic:
- cnt is 5 bits (0..16).
- mod output is cnt[3:0], so 16 maps to 0.
- gap counter width is $clog2(GAP_CYCLES+1) and saturates at GAP_CYCLES.

Errors:
- There is no backpressure; the consumer must accept every pulse.

Test Plan:
- Reset then 16 continuous bits of 0xB005 MSB-first -> one cycle after the last bit: val=1, data=0xB005, mod=0, short=0; val stays 0 during collection.
- 6 bits 101100 then val low (GAP_CYCLES=1) -> data=0xB000, mod=6, val pulses once, short=0.
- 32 continuous bits 0xB005 then 0x1234 -> two val pulses 16 cycles apart carrying 0xB005 then 0x1234, both with mod=0.
- GAP_CYCLES=3: 4 bits 1101, 2 invalid cycles, 4 bits 0011, then 3 invalid -> single pulse data=0xD300, mod=8; no pulse after the first gap.
- 2 bits 10 then val low -> data=0x8000, mod=2, val=1, short=1.
- srst_i asserted after 9 bits of a word, then 16 bits 0xFFFF -> no pulse for the aborted word; next pulse data=0xFFFF, mod=0; all outputs 0 during reset.
- Loopback: serializer drives this block with (0xB000, mod 6) and (0xB005, mod 0) -> outputs match the inputs exactly.
